// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DONE_ADR  = 32'd84;
  localparam logic [31:0] DONE_DATA = 32'd7;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, contents not reset.
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with IDLE/WAIT/RESP handshake.
// Optional store-completion detector enabled by DMEM_DONE_DET_EN.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        ready,
  output logic        err,
  output logic        done
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t          state;
  logic [3:0]      cnt;
  logic            cap_we;
  logic [AW-1:0]   cap_idx;
  logic [31:0]     cap_wdata;

  logic            adr_bad;
  logic            accept;
  logic            enter_resp;
  logic            acc_we;
  logic            acc_bad;
  logic            wr_en;
  logic [AW-1:0]   acc_idx;
  logic [31:0]     acc_wdata;
  logic [31:0]     rdata;

  assign adr_bad = (dataadr[1:0] != 2'b00) ||
                   ({2'b00, dataadr[31:2]} >= 32'(DEPTH));
  assign accept  = (state == IDLE) && req;

  // In IDLE the live request is the access; afterwards the captured copy is.
  assign acc_we    = (state == IDLE) ? memwrite : cap_we;
  assign acc_idx   = (state == IDLE) ? dataadr[AW+1:2] : cap_idx;
  assign acc_wdata = (state == IDLE) ? writedata : cap_wdata;
  assign acc_bad   = (state == IDLE) && adr_bad;

  // Rejected addresses never enter WAIT, so only the accept edge can flag err.
  assign enter_resp = (accept && ((LATENCY == 0) || adr_bad)) ||
                      ((state == WAIT) && (cnt == 4'd1));
  assign wr_en      = enter_resp && acc_we && !acc_bad;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      cap_we    <= memwrite;
      cap_idx   <= dataadr[AW+1:2];
      cap_wdata <= writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      ready    <= 1'b0;
      err      <= 1'b0;
      readdata <= 32'd0;
    end else begin
      ready    <= enter_resp;
      err      <= enter_resp && acc_bad;
      readdata <= (enter_resp && !acc_we && !acc_bad) ? rdata : 32'd0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (enter_resp) begin
              state <= RESP;
              cnt   <= 4'd0;
            end else begin
              state <= WAIT;
              cnt   <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_DONE_DET_EN
  logic done_hit;

  assign done_hit = wr_en && (30'(acc_idx) == DONE_ADR[31:2]) &&
                    (acc_wdata == DONE_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        done <= 1'b0;
    else if (done_hit) done <= 1'b1;
  end
`else
  assign done = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances side by side.
module tb_dmem_responder;

`ifdef DMEM_DONE_DET_EN
  localparam bit DONE_EN = 1'b1;
`else
  localparam bit DONE_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        req0, mw0, req2, mw2;
  logic [31:0] adr0, wd0, adr2, wd2;
  logic [31:0] rd0, rd2;
  logic        rdy0, rdy2, err0, err2, done0, done2;

  int checks = 0;
  int errors = 0;
  bit dexp0  = 1'b0;
  bit dexp2  = 1'b0;

  typedef struct {
    bit          mw;
    logic [31:0] adr;
    logic [31:0] wd;
    bit          xerr;
    logic [31:0] xrd;
  } vec_t;

  vec_t vt[12];

  dmem_responder #(.DEPTH(64), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset), .req(req2), .memwrite(mw2), .dataadr(adr2),
    .writedata(wd2), .readdata(rd2), .ready(rdy2), .err(err2), .done(done2)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset), .req(req0), .memwrite(mw0), .dataadr(adr0),
    .writedata(wd0), .readdata(rd0), .ready(rdy0), .err(err0), .done(done0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic r, input logic m,
                       input logic [31:0] a, input logic [31:0] d);
    if (w == 0) begin
      req0 = r; mw0 = m; adr0 = a; wd0 = d;
    end else begin
      req2 = r; mw2 = m; adr2 = a; wd2 = d;
    end
  endtask

  function automatic logic get_rdy(input int w);
    return (w == 0) ? rdy0 : rdy2;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 0) ? err0 : err2;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 0) ? done0 : done2;
  endfunction
  function automatic logic [31:0] get_rd(input int w);
    return (w == 0) ? rd0 : rd2;
  endfunction

  // Called one time unit after a rising edge with the instance idle; returns likewise.
  task automatic access(input int w, input bit m, input logic [31:0] a,
                        input logic [31:0] d, input bit xerr,
                        input logic [31:0] xrd, input string nm);
    int lat;
    int xlat;
    bit seen;
    xlat = (xerr || w == 0) ? 0 : 2;
    drive(w, 1'b1, m, a, d);
    @(posedge clk); #1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      if (get_rdy(w)) seen = 1'b1;
      else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    drive(w, 1'b0, 1'b0, 32'd0, 32'd0);
    if (DONE_EN && m && a == 32'd84 && d == 32'd7 && !xerr) begin
      if (w == 0) dexp0 = 1'b1;
      else        dexp2 = 1'b1;
    end
    chk({nm, ".ready_seen"}, 32'(seen), 32'd1);
    chk({nm, ".cycles"}, 32'(lat + 1), 32'(xlat + 1));
    chk({nm, ".err"}, 32'(get_err(w)), 32'(xerr));
    chk({nm, ".readdata"}, get_rd(w), xrd);
    chk({nm, ".done"}, 32'(get_done(w)), 32'((w == 0) ? dexp0 : dexp2));
    @(posedge clk); #1;
    chk({nm, ".ready_err_drop"}, 32'({get_rdy(w), get_err(w)}), 32'd0);
    chk({nm, ".readdata_idle"}, get_rd(w), 32'd0);
  endtask

  initial begin
    logic [15:0] pat0, pat2;

    vt[0]  = '{1'b1, 32'd84,         32'd7,         1'b0, 32'd0};
    vt[1]  = '{1'b0, 32'd84,         32'd0,         1'b0, 32'd7};
    vt[2]  = '{1'b1, 32'd0,          32'h12345678,  1'b0, 32'd0};
    vt[3]  = '{1'b1, 32'd80,         32'h11110000,  1'b0, 32'd0};
    vt[4]  = '{1'b1, 32'h53,         32'h0000AAAA,  1'b1, 32'd0};
    vt[5]  = '{1'b1, 32'd256,        32'h0000BBBB,  1'b1, 32'd0};
    vt[6]  = '{1'b0, 32'd80,         32'd0,         1'b0, 32'h11110000};
    vt[7]  = '{1'b0, 32'd0,          32'd0,         1'b0, 32'h12345678};
    vt[8]  = '{1'b0, 32'h51,         32'd0,         1'b1, 32'd0};
    vt[9]  = '{1'b1, 32'd252,        32'hFFFFFFFF,  1'b0, 32'd0};
    vt[10] = '{1'b0, 32'd252,        32'd0,         1'b0, 32'hFFFFFFFF};
    vt[11] = '{1'b0, 32'hFFFFFFFC,   32'd0,         1'b1, 32'd0};

    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    #2;
    chk("rst.ready2", 32'(rdy2), 32'd0);
    chk("rst.err2", 32'(err2), 32'd0);
    chk("rst.readdata2", rd2, 32'd0);
    chk("rst.done2", 32'(done2), 32'd0);
    chk("rst.ready0", 32'(rdy0), 32'd0);
    chk("rst.readdata0", rd0, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    // Completion flag: wrong data first, then the magic store, then a later store.
    access(2, 1'b1, 32'd84, 32'd6, 1'b0, 32'd0, "done_st6");
    access(2, 1'b1, 32'd84, 32'd7, 1'b0, 32'd0, "done_st7");
    access(2, 1'b1, 32'd84, 32'd5, 1'b0, 32'd0, "done_st5");

    for (int i = 0; i < 12; i++)
      access(2, vt[i].mw, vt[i].adr, vt[i].wd, vt[i].xerr, vt[i].xrd,
             $sformatf("vec%0d", i));

    access(0, 1'b1, 32'd80, 32'h1234, 1'b0, 32'd0, "lat0_st80");
    access(0, 1'b0, 32'd80, 32'd0, 1'b0, 32'h00001234, "lat0_ld80");
    access(0, 1'b1, 32'h53, 32'h9999, 1'b1, 32'd0, "lat0_st53");
    access(0, 1'b0, 32'd80, 32'd0, 1'b0, 32'h00001234, "lat0_ld80b");

    // req held continuously on both instances.
    drive(2, 1'b1, 1'b0, 32'd84, 32'd0);
    drive(0, 1'b1, 1'b0, 32'd80, 32'd0);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      pat2[i] = rdy2;
      pat0[i] = rdy0;
    end
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("hold.ready_pattern_lat2", 32'(pat2), 32'h4444);
    chk("hold.ready_pattern_lat0", 32'(pat0), 32'h5555);
    @(posedge clk); #1;

    // Reset during WAIT of a store, with the LATENCY=0 instance mid-response.
    access(2, 1'b1, 32'd8, 32'h55550008, 1'b0, 32'd0, "pre_st8");
    drive(2, 1'b1, 1'b1, 32'd8, 32'h0000DEAD);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'd80, 32'd0);
    @(posedge clk); #1;
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rstwait.pre_ready2", 32'(rdy2), 32'd0);
    chk("rstwait.pre_ready0", 32'(rdy0), 32'd1);
    chk("rstwait.pre_readdata0", rd0, 32'h00001234);
    chk("rstwait.pre_done2", 32'(done2), 32'(DONE_EN));
    reset = 1'b0;
    #1;
    dexp0 = 1'b0;
    dexp2 = 1'b0;
    chk("rstwait.ready0", 32'(rdy0), 32'd0);
    chk("rstwait.readdata0", rd0, 32'd0);
    chk("rstwait.ready2", 32'(rdy2), 32'd0);
    chk("rstwait.err2", 32'(err2), 32'd0);
    chk("rstwait.done2", 32'(done2), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    access(2, 1'b0, 32'd8, 32'd0, 1'b0, 32'h55550008, "post_rst_ld8");
    access(2, 1'b0, 32'd84, 32'd0, 1'b0, 32'd7, "post_rst_ld84");
    access(0, 1'b0, 32'd80, 32'd0, 1'b0, 32'h00001234, "post_rst_ld80");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words stored.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles between request accept and response (legal range 0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port req  input  1  processor access request, held until ready.
REQ-006 SHALL have port memwrite  input  1  1 = store, 0 = load; valid with req.
REQ-007 SHALL have port dataadr  input  32  byte address; valid with req.
REQ-008 SHALL have port writedata  input  32  store data; valid with req.
REQ-009 SHALL have port readdata  output  32  load data; valid when ready=1 and err=0.
REQ-010 SHALL have port ready  output  1  one-cycle response strobe.
REQ-011 SHALL have port err  output  1  access rejected; valid with ready.
REQ-012 SHALL have port done  output  1  sticky completion flag (see Configuration).

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-014 IDLE: on edge with req=1, capture memwrite/dataadr/writedata, load latency counter with LATENCY, go WAIT (or RESP if LATENCY=0).
REQ-015 WAIT: decrement counter each cycle; go RESP on the edge where counter reaches 0; inputs ignored.
REQ-016 RESP: ready=1 for exactly one cycle, then IDLE unconditionally; req during RESP not accepted.
REQ-017 Access latency from accepting edge to ready high SHALL be LATENCY+1 cycles; throughput one access per LATENCY+2 cycles.
REQ-018 Store SHALL commit to word dataadr[31:2] on the edge entering RESP; readdata=0 during store response.
REQ-019 Load SHALL present stored word on readdata during RESP; readdata=0 outside RESP.
REQ-020 Captured address with dataadr[1:0]!=0 or dataadr[31:2]>=DEPTH SHALL skip WAIT, enter RESP next edge with err=1, no write, readdata=0.
REQ-021 err SHALL be 0 whenever ready=0.
REQ-022 Load from a word not written since power-up SHALL return unspecified data (storage not reset).

Reset
REQ-023 reset=0 SHALL immediately force state IDLE, counter 0, ready=0, err=0, readdata=0, done=0.
REQ-024 Reset asserted in WAIT SHALL abort the access with no write; storage contents SHALL be preserved.
REQ-025 First request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro DMEM_DONE_DET_EN: when defined, done SHALL set on the edge committing a store of 32'd7 to address 84 and remain 1 until reset; stores to 84 with other data SHALL not set it.
REQ-027 Without DMEM_DONE_DET_EN, done SHALL be tied 0 and no detection logic instantiated.

Structure
REQ-028 Package dmem_pkg SHALL hold the state enum and constants DONE_ADR=84, DONE_DATA=7.
REQ-029 Storage SHALL be a sub-module dmem_array (synchronous write, combinational read, DEPTH words); FSM, counter, and checking in dmem_responder.

Verification
REQ-030 Store 7 to 84, LATENCY=2: ready high exactly 3 cycles after accept, err=0; then load 84 -> readdata=7.
REQ-031 Load 80 after store 0x1234 to 80 with LATENCY=0: ready on next cycle, readdata=0x00001234.
REQ-032 Store to 0x53 (misaligned) and to 4*DEPTH: ready next cycle, err=1; subsequent load of 0x50 unchanged.
REQ-033 req held high continuously: accepts separated by exactly LATENCY+2 cycles, one ready per access.
REQ-034 Reset pulsed during WAIT of store 0xDEAD to 8: outputs 0 immediately, word 8 keeps prior value.
REQ-035 With DMEM_DONE_DET_EN: store 6 to 84 -> done=0; store 7 to 84 -> done=1 after commit edge, stays 1 through later stores; without macro done=0 throughout.
